// File: rtl/alu_mul_seq_g7.sv
// alu_mul_seq_g7: shift-and-add 32x32 multiplier (low 32 bits) that borrows the shared ALU
module alu_mul_seq_g7 #(
    parameter bit EARLY_EXIT = 1'b1,
    parameter int ITER_MAX   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [5:0]  iter_cnt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);
    // ALU operation codes of the shared core ALU
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0101;

    typedef enum logic [2:0] {IDLE, TEST, ADD, DBL, SHR, DONE} state_t;

    state_t      state_q;
    logic [31:0] acc_q, mcand_q, mplier_q, product_q;
    logic [5:0]  iter_q;
    logic        busy_q, done_q;

    assign busy     = busy_q;
    assign done     = done_q;
    assign product  = product_q;
    assign iter_cnt = iter_q;

    // Every state except IDLE/DONE owns the ALU; the operation is a pure function of the state
    always_comb begin
        alu_a    = (state_q == TEST || state_q == SHR) ? mplier_q :
                   (state_q == ADD) ? acc_q : (state_q == DBL) ? mcand_q : 32'd0;
        alu_b    = (state_q == ADD || state_q == DBL) ? mcand_q : (state_q == SHR) ? 32'd1 : 32'd0;
        alu_ctrl = (state_q == TEST) ? ALU_OR : (state_q == SHR) ? ALU_SRL : ALU_ADD;
    end

    // Sequencer: each state lasts one cycle and captures the ALU result on its closing edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            iter_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    mcand_q  <= op_a;
                    mplier_q <= op_b;
                    acc_q    <= '0;
                    iter_q   <= '0;
                    busy_q   <= 1'b1;
                    state_q  <= TEST;
                end
                TEST: if ((EARLY_EXIT && alu_zero) || iter_q == 6'(ITER_MAX)) begin
                    product_q <= acc_q;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end else begin
                    state_q <= mplier_q[0] ? ADD : DBL;
                end
                ADD: begin
                    acc_q   <= alu_result;
                    state_q <= DBL;
                end
                DBL: begin
                    mcand_q <= alu_result;
                    state_q <= SHR;
                end
                SHR: begin
                    mplier_q <= alu_result;
                    iter_q   <= iter_q + 6'd1;
                    state_q  <= TEST;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
